// File: rtl/pipelined_addsub_if.sv
// Handshake and data bundle for the pipelined add/subtract unit.
// The producer/consumer side uses the master modport, the unit uses slave.
interface pipelined_addsub_if #(
    parameter int WIDTH     = 32,
    parameter int TAG_WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 in_cin;
    logic                 in_sub;
    logic [TAG_WIDTH-1:0] in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_sum;
    logic                 out_n;
    logic                 out_z;
    logic                 out_c;
    logic                 out_v;
    logic [TAG_WIDTH-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
        input  in_ready, out_valid, out_sum, out_n, out_z, out_c, out_v, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
        output in_ready, out_valid, out_sum, out_n, out_z, out_c, out_v, out_tag
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit. The WIDTH-bit operation is split into STAGES
// segments of SEG bits; stage i adds segment i using the carry registered by
// stage i-1. The last stage register drives the outputs directly and also
// holds the precomputed NZCV flags, so no logic sits after the final flops.
module pipelined_addsub #(
    parameter int WIDTH     = 32,
    parameter int STAGES    = 4,
    parameter int TAG_WIDTH = 4
) (
    input logic              clk,
    input logic              rst,
    pipelined_addsub_if.slave bus
);
    localparam int SEG = WIDTH / STAGES;

    logic [STAGES-1:0]    valid_q;
    logic [STAGES-1:0]    carry_q;
    logic [STAGES-1:0]    zero_q;
    logic [WIDTH-1:0]     sum_q [STAGES];
    logic [WIDTH-1:0]     a_q   [STAGES];
    logic [WIDTH-1:0]     b_q   [STAGES];
    logic [TAG_WIDTH-1:0] tag_q [STAGES];
    logic                 v_q;

    logic [STAGES-1:0]    ready;
    logic [STAGES-1:0]    src_valid;
    logic [STAGES-1:0]    src_carry;
    logic [STAGES-1:0]    src_zero;
    logic [WIDTH-1:0]     src_a   [STAGES];
    logic [WIDTH-1:0]     src_b   [STAGES];
    logic [WIDTH-1:0]     src_sum [STAGES];
    logic [TAG_WIDTH-1:0] src_tag [STAGES];

    logic [STAGES-1:0]    carry_d;
    logic [STAGES-1:0]    zero_d;
    logic [WIDTH-1:0]     sum_d [STAGES];
    logic                 v_d;

    // A stage can advance unless it and every stage after it is full while
    // the consumer stalls; written in closed form to avoid a ready->ready chain.
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        ready    = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            all_full = all_full & valid_q[i];
            ready[i] = bus.out_ready | ~all_full;
        end
    end

    // Stage inputs: stage 0 takes the bus (B inverted once for subtract),
    // later stages take the previous stage's registers.
    always_comb begin
        src_valid[0] = bus.in_valid;
        src_a[0]     = bus.in_a;
        src_b[0]     = bus.in_sub ? ~bus.in_b : bus.in_b;
        src_carry[0] = bus.in_cin;
        src_sum[0]   = '0;
        src_zero[0]  = 1'b1;
        src_tag[0]   = bus.in_tag;
        for (int i = 1; i < STAGES; i++) begin
            src_valid[i] = valid_q[i-1];
            src_a[i]     = a_q[i-1];
            src_b[i]     = b_q[i-1];
            src_carry[i] = carry_q[i-1];
            src_sum[i]   = sum_q[i-1];
            src_zero[i]  = zero_q[i-1];
            src_tag[i]   = tag_q[i-1];
        end
    end

    // Per-stage segment adder; the top segment also produces the overflow flag
    // from the carry into the MSB (recovered as s ^ a ^ b at that bit).
    always_comb begin
        logic [SEG:0]   seg_res;
        logic [SEG-1:0] a_seg;
        logic [SEG-1:0] b_seg;
        seg_res = '0;
        a_seg   = '0;
        b_seg   = '0;
        carry_d = '0;
        zero_d  = '0;
        v_d     = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            a_seg      = src_a[i][i*SEG +: SEG];
            b_seg      = src_b[i][i*SEG +: SEG];
            seg_res    = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, src_carry[i]};
            sum_d[i]   = src_sum[i];
            sum_d[i][i*SEG +: SEG] = seg_res[SEG-1:0];
            carry_d[i] = seg_res[SEG];
            zero_d[i]  = src_zero[i] & (seg_res[SEG-1:0] == '0);
            if (i == STAGES - 1) begin
                v_d = (seg_res[SEG-1] ^ a_seg[SEG-1] ^ b_seg[SEG-1]) ^ seg_res[SEG];
            end
        end
    end

    // Stage registers: load on advance; data only changes for a valid entry so
    // the outputs hold their last values while the pipeline drains empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            zero_q  <= '0;
            v_q     <= 1'b0;
            for (int i = 0; i < STAGES; i++) begin
                sum_q[i] <= '0;
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (ready[i]) begin
                    valid_q[i] <= src_valid[i];
                    if (src_valid[i]) begin
                        sum_q[i]   <= sum_d[i];
                        carry_q[i] <= carry_d[i];
                        zero_q[i]  <= zero_d[i];
                        a_q[i]     <= src_a[i];
                        b_q[i]     <= src_b[i];
                        tag_q[i]   <= src_tag[i];
                    end
                end
            end
            if (ready[STAGES-1] && src_valid[STAGES-1]) begin
                v_q <= v_d;
            end
        end
    end

    assign bus.in_ready  = ready[0];
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.out_sum   = sum_q[STAGES-1];
    assign bus.out_n     = sum_q[STAGES-1][WIDTH-1];
    assign bus.out_z     = zero_q[STAGES-1];
    assign bus.out_c     = carry_q[STAGES-1];
    assign bus.out_v     = v_q;
    assign bus.out_tag   = tag_q[STAGES-1];
endmodule
